alu_rs: RTL and testbench

- Reservation station that feeds the combinational ALU in the execute stage and carries each result back onto the common data bus (CDB).
- Holds dispatched ALU instructions until both operands are available, snooping the CDB for missing operands.
- Issues one ready instruction per cycle to the ALU and broadcasts the result, tagged with its ROB index, one cycle later.

---
 rtl/alu_rs.sv | 197 +++++++++++++++++++
 tb/tb_alu_rs.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the execute-stage ALU, snooping the CDB for pending operands.
// Optional ALU_RS_BYPASS_EN: an entry may issue in the same cycle its last operand appears on the CDB.
module alu_rs #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             disp_valid,
  input  logic [2:0]       disp_op,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic             disp_qj_busy,
  input  logic             disp_qk_busy,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [TAG_W-1:0] disp_dest,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic [31:0]      alu_rs1,
  output logic [31:0]      alu_rs2,
  output logic [2:0]       alu_op,
  input  logic [31:0]      alu_result,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      out_value
);

  localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] qj_busy_q, qj_busy_d;
  logic [RS_SIZE-1:0] qk_busy_q, qk_busy_d;
  logic [2:0]         op_q   [RS_SIZE];
  logic [2:0]         op_d   [RS_SIZE];
  logic [31:0]        vj_q   [RS_SIZE];
  logic [31:0]        vj_d   [RS_SIZE];
  logic [31:0]        vk_q   [RS_SIZE];
  logic [31:0]        vk_d   [RS_SIZE];
  logic [TAG_W-1:0]   qj_q   [RS_SIZE];
  logic [TAG_W-1:0]   qj_d   [RS_SIZE];
  logic [TAG_W-1:0]   qk_q   [RS_SIZE];
  logic [TAG_W-1:0]   qk_d   [RS_SIZE];
  logic [TAG_W-1:0]   dest_q [RS_SIZE];
  logic [TAG_W-1:0]   dest_d [RS_SIZE];

  logic               out_valid_q, out_valid_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic [31:0]        out_value_q, out_value_d;

  logic [RS_SIZE-1:0] j_hit, k_hit, cand;
  logic [31:0]        opj [RS_SIZE];
  logic [31:0]        opk [RS_SIZE];
  logic               free_found, sel_found;
  logic [IDX_W-1:0]   free_idx, sel_idx;
  logic               disp_j_hit, disp_k_hit;

  // Per-entry CDB match and issue eligibility, all from registered state.
  always_comb begin
    j_hit = '0;
    k_hit = '0;
    cand  = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      j_hit[i] = qj_busy_q[i] && cdb_valid && (qj_q[i] == cdb_tag);
      k_hit[i] = qk_busy_q[i] && cdb_valid && (qk_q[i] == cdb_tag);
`ifdef ALU_RS_BYPASS_EN
      opj[i]  = j_hit[i] ? cdb_value : vj_q[i];
      opk[i]  = k_hit[i] ? cdb_value : vk_q[i];
      cand[i] = busy_q[i] && (!qj_busy_q[i] || j_hit[i]) && (!qk_busy_q[i] || k_hit[i]);
`else
      opj[i]  = vj_q[i];
      opk[i]  = vk_q[i];
      cand[i] = busy_q[i] && !qj_busy_q[i] && !qk_busy_q[i];
`endif
    end
  end

  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (cand[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    full    = &busy_q;
    alu_rs1 = sel_found ? opj[sel_idx]  : '0;
    alu_rs2 = sel_found ? opk[sel_idx]  : '0;
    alu_op  = sel_found ? op_q[sel_idx] : '0;
  end

  assign disp_j_hit = disp_qj_busy && cdb_valid && (disp_qj == cdb_tag);
  assign disp_k_hit = disp_qk_busy && cdb_valid && (disp_qk == cdb_tag);

  always_comb begin
    busy_d      = busy_q;
    qj_busy_d   = qj_busy_q;
    qk_busy_d   = qk_busy_q;
    op_d        = op_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    dest_d      = dest_q;
    out_valid_d = 1'b0;
    out_tag_d   = out_tag_q;
    out_value_d = out_value_q;

    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i] && j_hit[i]) begin
        vj_d[i]      = cdb_value;
        qj_busy_d[i] = 1'b0;
      end
      if (busy_q[i] && k_hit[i]) begin
        vk_d[i]      = cdb_value;
        qk_busy_d[i] = 1'b0;
      end
    end

    if (sel_found) begin
      busy_d[sel_idx] = 1'b0;
      out_valid_d     = 1'b1;
      out_tag_d       = dest_q[sel_idx];
      out_value_d     = alu_result;
    end

    // Free slot is chosen from pre-edge state, so an entry issuing now is never reused this cycle.
    if (disp_valid && free_found) begin
      busy_d[free_idx]    = 1'b1;
      op_d[free_idx]      = disp_op;
      qj_d[free_idx]      = disp_qj;
      qk_d[free_idx]      = disp_qk;
      dest_d[free_idx]    = disp_dest;
      vj_d[free_idx]      = disp_j_hit ? cdb_value : disp_vj;
      vk_d[free_idx]      = disp_k_hit ? cdb_value : disp_vk;
      qj_busy_d[free_idx] = disp_qj_busy && !disp_j_hit;
      qk_busy_d[free_idx] = disp_qk_busy && !disp_k_hit;
    end

    if (flush_in) begin
      busy_d      = '0;
      out_valid_d = 1'b0;
      out_tag_d   = out_tag_q;
      out_value_d = out_value_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q      <= '0;
      qj_busy_q   <= '0;
      qk_busy_q   <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_value_q <= '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        op_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        dest_q[i] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      qj_busy_q   <= qj_busy_d;
      qk_busy_q   <= qk_busy_d;
      op_q        <= op_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      dest_q      <= dest_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_value_q <= out_value_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_value = out_value_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus randomized dependency traffic against a result scoreboard.
module tb_alu_rs;
  localparam int unsigned RS_SIZE = 8;
  localparam int unsigned TAG_W   = 4;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic             flush_in = 1'b0;
  logic             disp_valid = 1'b0;
  logic [2:0]       disp_op = '0;
  logic [31:0]      disp_vj = '0, disp_vk = '0;
  logic             disp_qj_busy = 1'b0, disp_qk_busy = 1'b0;
  logic [TAG_W-1:0] disp_qj = '0, disp_qk = '0, disp_dest = '0;
  logic             full;
  logic             cdb_valid = 1'b0;
  logic [TAG_W-1:0] cdb_tag = '0;
  logic [31:0]      cdb_value = '0;
  logic [31:0]      alu_rs1, alu_rs2, alu_result;
  logic [2:0]       alu_op;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [31:0]      out_value;

  int n_cmp = 0;
  int n_err = 0;

  alu_rs #(.RS_SIZE(RS_SIZE), .TAG_W(TAG_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy), .disp_qj(disp_qj), .disp_qk(disp_qk),
    .disp_dest(disp_dest), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op(alu_op), .alu_result(alu_result),
    .out_valid(out_valid), .out_tag(out_tag), .out_value(out_value)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return 32'($signed(a) >>> b[4:0]);
    endcase
  endfunction

  // The bench plays the combinational ALU.
  always_comb alu_result = alu_f(alu_op, alu_rs1, alu_rs2);

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush_in   = 1'b0;
  endtask

  task automatic disp(input logic [2:0] op, input logic [31:0] vj, input logic [31:0] vk,
                      input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk,
                      input logic [3:0] dest);
    disp_valid = 1'b1; disp_op = op; disp_vj = vj; disp_vk = vk;
    disp_qj_busy = qjb; disp_qj = qj; disp_qk_busy = qkb; disp_qk = qk; disp_dest = dest;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({full, out_valid, out_tag, out_value} !== '0) begin
      n_err++;
      $display("FAIL reset_out: full=%b ov=%b tag=%0d val=%h, expected all zero", full, out_valid, out_tag, out_value);
    end
    n_cmp++;
    if ({alu_rs1, alu_rs2, alu_op} !== '0) begin
      n_err++;
      $display("FAIL reset_alu: rs1=%h rs2=%h op=%0d, expected 0", alu_rs1, alu_rs2, alu_op);
    end
  endtask

  task automatic test_basic_add();
    disp(3'd0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    tick(); idle();
    n_cmp++;
    if (alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7 || alu_op !== 3'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL add_select: rs1=%0d rs2=%0d op=%0d ov=%b, expected 5 7 0 0", alu_rs1, alu_rs2, alu_op, out_valid);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_value !== 32'd12 || out_tag !== 4'd3) begin
      n_err++;
      $display("FAIL add_result: ov=%b val=%0d tag=%0d, expected 1 12 3", out_valid, out_value, out_tag);
    end
    n_cmp++;
    if (alu_rs1 !== 32'd0 || full !== 1'b0) begin
      n_err++;
      $display("FAIL add_freed: rs1=%0d full=%b, expected 0 0", alu_rs1, full);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_tag !== 4'd3 || out_value !== 32'd12) begin
      n_err++;
      $display("FAIL add_hold: ov=%b tag=%0d val=%0d, expected 0 3 12", out_valid, out_tag, out_value);
    end
  endtask

  task automatic test_wakeup();
    disp(3'd1, 32'd0, 32'd1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd5);
    tick(); idle();
    for (int c = 0; c < 2; c++) begin
      n_cmp++;
      if (out_valid !== 1'b0 || alu_rs1 !== 32'd0) begin
        n_err++;
        $display("FAIL wake_blocked: ov=%b rs1=%0d, expected 0 0", out_valid, alu_rs1);
      end
      tick();
    end
    cdb(4'd3, 32'd10);
    tick(); idle();
`ifndef ALU_RS_BYPASS_EN
    n_cmp++;
    if (out_valid !== 1'b0 || alu_rs1 !== 32'd10 || alu_op !== 3'd1) begin
      n_err++;
      $display("FAIL wake_select: ov=%b rs1=%0d op=%0d, expected 0 10 1", out_valid, alu_rs1, alu_op);
    end
    tick();
`endif
    n_cmp++;
    if (out_valid !== 1'b1 || out_value !== 32'd9 || out_tag !== 4'd5) begin
      n_err++;
      $display("FAIL wake_result: ov=%b val=%0d tag=%0d, expected 1 9 5", out_valid, out_value, out_tag);
    end
    tick();
  endtask

  task automatic test_same_cycle_capture();
    disp(3'd7, 32'd0, 32'd4, 1'b1, 4'd2, 1'b0, 4'd0, 4'd6);
    cdb(4'd2, 32'h8000_0000);
    tick(); idle();
    n_cmp++;
    if (alu_rs1 !== 32'h8000_0000 || alu_rs2 !== 32'd4 || alu_op !== 3'd7) begin
      n_err++;
      $display("FAIL capture_select: rs1=%h rs2=%0d op=%0d, expected 80000000 4 7", alu_rs1, alu_rs2, alu_op);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_value !== 32'hF800_0000 || out_tag !== 4'd6) begin
      n_err++;
      $display("FAIL capture_result: ov=%b val=%h tag=%0d, expected 1 f8000000 6", out_valid, out_value, out_tag);
    end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      disp(3'd0, 32'd0, 32'(i + 1), 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(i));
      tick();
    end
    idle();
    n_cmp++;
    if (full !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL full_set: full=%b ov=%b, expected 1 0", full, out_valid);
    end
    disp(3'd0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    tick(); idle();
    n_cmp++;
    if (full !== 1'b1 || alu_rs1 !== 32'd0) begin
      n_err++;
      $display("FAIL full_ignore: full=%b rs1=%0d, expected 1 0", full, alu_rs1);
    end
    cdb(4'd8, 32'd100);
    tick(); idle();
`ifndef ALU_RS_BYPASS_EN
    n_cmp++;
    if (out_valid !== 1'b0 || full !== 1'b1) begin
      n_err++;
      $display("FAIL full_wake: ov=%b full=%b, expected 0 1", out_valid, full);
    end
    tick();
`endif
    n_cmp++;
    if (out_valid !== 1'b1 || out_value !== 32'd101 || out_tag !== 4'd0 || full !== 1'b0) begin
      n_err++;
      $display("FAIL full_drain: ov=%b val=%0d tag=%0d full=%b, expected 1 101 0 0", out_valid, out_value, out_tag, full);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL full_single: ov=%b tag=%0d, expected 0", out_valid, out_tag);
    end
    flush_in = 1'b1;
    tick(); idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      disp(3'd0, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 4'(i));
      tick();
    end
    disp(3'd0, 32'h55, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
    tick(); idle();
    flush_in = 1'b1;
    cdb(4'd12, 32'd1);
    disp(3'd0, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
    tick(); idle();
    n_cmp++;
    if (out_valid !== 1'b0 || full !== 1'b0 || alu_rs1 !== 32'd0) begin
      n_err++;
      $display("FAIL flush_clear: ov=%b full=%b rs1=%h, expected 0 0 0", out_valid, full, alu_rs1);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_quiet: ov=%b tag=%0d, expected 0", out_valid, out_tag);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] wait_tag [5];
    logic [3:0] order [2][3];
    wait_tag = '{4'd9, 4'd10, 4'd9, 4'd9, 4'd10};
    order = '{'{4'd1, 4'd4, 4'd0}, '{4'd0, 4'd2, 4'd3}};
    for (int i = 0; i < 5; i++) begin
      disp(3'd0, 32'd0, 32'(16 * i), 1'b1, wait_tag[i], 1'b0, 4'd0, 4'(i));
      tick();
    end
    idle();
    for (int r = 0; r < 2; r++) begin
      cdb(r == 0 ? 4'd10 : 4'd9, 32'(r + 1));
      tick(); idle();
`ifndef ALU_RS_BYPASS_EN
      tick();
`endif
      for (int k = 0; k < (r == 0 ? 2 : 3); k++) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_tag !== order[r][k] || out_value !== 32'(16 * order[r][k] + r + 1)) begin
          n_err++;
          $display("FAIL order_r%0d_k%0d: ov=%b tag=%0d val=%0d, expected 1 %0d %0d", r, k,
                   out_valid, out_tag, out_value, order[r][k], 16 * order[r][k] + r + 1);
        end
        tick();
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL order_end_r%0d: ov=%b, expected 0", r, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] pv [16];
    bit          pbc [16];
    logic [31:0] expv [16];
    bit          expok [16];
    bit          seen [16];
    for (int it = 0; it < 4; it++) begin
      int n_out = 0;
      for (int t = 0; t < 16; t++) begin
        pv[t] = $urandom; pbc[t] = 0; expok[t] = 0; seen[t] = 0;
      end
      for (int c = 0; c < 40; c++) begin
        int bt = -1;
        idle();
        if (c >= 12 || $urandom_range(0, 1) == 1) begin
          int off = $urandom_range(0, 7);
          for (int k = 0; k < 8; k++) begin
            int t = 8 + ((off + k) % 8);
            if (!pbc[t] && bt < 0) bt = t;
          end
        end
        if (bt >= 0) cdb(4'(bt), pv[bt]);
        if (c < 8) begin
          logic [2:0]  op  = 3'($urandom);
          logic [31:0] vj  = $urandom, vk = $urandom;
          logic        qjb = 1'($urandom), qkb = 1'($urandom);
          logic [3:0]  qj  = 4'(8 + $urandom_range(0, 7)), qk = 4'(8 + $urandom_range(0, 7));
          if (qjb && pbc[qj]) begin qjb = 1'b0; vj = pv[qj]; end
          if (qkb && pbc[qk]) begin qkb = 1'b0; vk = pv[qk]; end
          expv[c]  = alu_f(op, qjb ? pv[qj] : vj, qkb ? pv[qk] : vk);
          expok[c] = 1;
          disp(op, vj, vk, qjb, qj, qkb, qk, 4'(c));
        end
        if (bt >= 0) pbc[bt] = 1;
        tick();
        if (out_valid === 1'b1) begin
          n_cmp++;
          if (!expok[out_tag] || seen[out_tag] || out_value !== expv[out_tag]) begin
            n_err++;
            $display("FAIL rand_it%0d_result: tag=%0d val=%h dup=%0d, expected val %h", it, out_tag,
                     out_value, seen[out_tag], expv[out_tag]);
          end
          seen[out_tag] = 1;
          n_out++;
        end
      end
      idle();
      n_cmp++;
      if (n_out != 8) begin
        n_err++;
        $display("FAIL rand_it%0d_count: got %0d results, expected 8", it, n_out);
      end
    end
  endtask

  task automatic test_mid_reset();
    disp(3'd0, 32'h1234, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    tick(); idle();
    n_cmp++;
    if (alu_rs1 !== 32'h1234) begin
      n_err++;
      $display("FAIL mid_reset_pre: rs1=%h, expected 1234", alu_rs1);
    end
    #1 rst_in = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, out_tag, out_value, alu_rs1, alu_rs2, alu_op, full} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: ov=%b tag=%0d val=%h rs1=%h op=%0d full=%b, expected all zero",
               out_valid, out_tag, out_value, alu_rs1, alu_op, full);
    end
    #1 rst_in = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || alu_rs1 !== 32'd0) begin
      n_err++;
      $display("FAIL post_reset: ov=%b rs1=%h, expected 0 0", out_valid, alu_rs1);
    end
  endtask

  initial begin
    #12;
    test_reset();
    rst_in = 1'b0;
    tick();
    test_basic_add();
    test_wakeup();
    test_same_cycle_capture();
    test_full();
    test_flush();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
